// File: rtl/ctrl_stream_tx.sv
// Byte-FIFO-fed 8N1 UART transmitter. The frame FSM pops the FIFO head on
// entry to START; o_tx and o_busy are registered one cycle behind the state.
module ctrl_stream_tx #(
   parameter int TICKS_PER_BIT = 9,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                         i_clk,
   input  logic                         reset,
   input  logic                         i_enable,
   input  logic [7:0]                   i_data,
   input  logic                         i_wr,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(FIFO_DEPTH):0]  o_level,
   output logic                         o_overflow,
   output logic                         o_busy,
   output logic                         o_tx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TICKS_PER_BIT);
   localparam logic [AW:0]   FULL_LVL = FIFO_DEPTH[AW:0];
   localparam logic [TW-1:0] TMAX     = TW'(TICKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   level;
   logic          push, pop, bit_end;

   assign o_level = level;
   assign o_full  = (level == FULL_LVL);
   assign o_empty = (level == '0);
   assign bit_end = (timer == TMAX);
   // A full FIFO drops the push even when a pop frees a slot this cycle.
   assign push    = i_wr && !o_full;
   assign pop     = !o_empty && i_enable && ((state == IDLE) || (state == STOP && bit_end));

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         level      <= '0;
         o_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (i_wr && o_full) o_overflow <= 1'b1;
         case ({push, pop})
            2'b10:   level <= level + (AW+1)'(1);
            2'b01:   level <= level - (AW+1)'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         o_tx    <= 1'b1;
         o_busy  <= 1'b0;
      end else begin
         o_tx   <= (state == START) ? 1'b0 : (state == DATA) ? shreg[0] : 1'b1;
         o_busy <= (state != IDLE);
         case (state)
            IDLE: begin
               timer <= '0;
               if (pop) begin
                  state <= START;
                  shreg <= mem[rd_ptr];
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  timer   <= '0;
                  bit_idx <= '0;
               end else timer <= timer + TW'(1);
            end
            DATA: begin
               if (bit_end) begin
                  timer <= '0;
                  shreg <= shreg >> 1;
                  if (bit_idx == 3'd7) state <= STOP;
                  else bit_idx <= bit_idx + 3'd1;
               end else timer <= timer + TW'(1);
            end
            STOP: begin
               if (bit_end) begin
                  timer <= '0;
                  // Chain straight into the next frame with no idle gap.
                  if (pop) begin
                     state <= START;
                     shreg <= mem[rd_ptr];
                  end else state <= IDLE;
               end else timer <= timer + TW'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ctrl_stream_tx.sv
// Bench for ctrl_stream_tx: frame-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ctrl_stream_tx;
   localparam int T     = 4;
   localparam int DEPTH = 16;

   logic       i_clk = 1'b0;
   logic       reset;
   logic       i_enable;
   logic [7:0] i_data;
   logic       i_wr;
   logic       o_full, o_empty, o_overflow, o_busy, o_tx;
   logic [$clog2(DEPTH):0] o_level;

   int tests = 0;
   int fails = 0;
   bit chk_on = 1'b0;

   ctrl_stream_tx #(.TICKS_PER_BIT(T), .FIFO_DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .reset(reset), .i_enable(i_enable), .i_data(i_data),
      .i_wr(i_wr), .o_full(o_full), .o_empty(o_empty), .o_level(o_level),
      .o_overflow(o_overflow), .o_busy(o_busy), .o_tx(o_tx)
   );

   always #5 i_clk = ~i_clk;

   // Reference model: a byte queue plus "cycles left in the current frame".
   byte unsigned q[$];
   int           fr;
   byte unsigned cur;
   bit           m_tx, m_busy, m_ovf;
   int           m_level;

   always @(posedge i_clk or posedge reset) begin
      if (reset) begin
         q.delete();
         fr = 0; cur = 0; m_tx = 1; m_busy = 0; m_ovf = 0; m_level = 0;
      end else begin
         bit push_ok, can_start;
         int p, idx;
         if (fr == 0) begin
            m_tx = 1; m_busy = 0;
         end else begin
            p = 10*T - fr; idx = p / T;
            m_tx = (idx == 0) ? 1'b0 : (idx == 9) ? 1'b1 : cur[idx-1];
            m_busy = 1;
         end
         push_ok   = i_wr && (q.size() < DEPTH);
         can_start = (q.size() != 0) && i_enable;
         if (i_wr && !push_ok) m_ovf = 1;
         if ((fr <= 1) && can_start) begin
            cur = q.pop_front();
            fr  = 10*T;
         end else if (fr != 0) fr = fr - 1;
         if (push_ok) q.push_back(i_data);
         m_level = q.size();
      end
   end

   always @(negedge i_clk) begin
      if (chk_on) begin
         tests++;
         if (o_tx !== m_tx || o_busy !== m_busy || int'(o_level) != m_level ||
             o_full !== (m_level == DEPTH) || o_empty !== (m_level == 0) || o_overflow !== m_ovf) begin
            fails++;
            $display("FAIL cycle_cmp t=%0t tx=%b/%b busy=%b/%b level=%0d/%0d full=%b empty=%b ovf=%b/%b",
                     $time, o_tx, m_tx, o_busy, m_busy, o_level, m_level, o_full, o_empty, o_overflow, m_ovf);
         end
      end
   end

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s got=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic push(input byte unsigned d);
      i_wr = 1; i_data = d;
      @(negedge i_clk);
      i_wr = 0;
   endtask

   initial begin
      logic [39:0] cap;
      int nbusy, peak, rises, tx1;
      bit prev_busy;

      reset = 1; i_enable = 0; i_wr = 0; i_data = 0;
      repeat (3) @(negedge i_clk);
      check("rst_tx", o_tx, 1);
      check("rst_busy", o_busy, 0);
      check("rst_empty", o_empty, 1);
      check("rst_level", o_level, 0);
      reset = 0; chk_on = 1;
      @(negedge i_clk);

      // Single byte 0x55
      i_enable = 1;
      push(8'h55);
      cap = '0; nbusy = 0; tx1 = 0;
      for (int i = 0; i < 48; i++) begin
         @(negedge i_clk);
         if (i == 0) tx1 = o_tx;
         if (i >= 1 && i <= 40) cap = {cap[38:0], o_tx};
         nbusy += int'(o_busy);
      end
      check("single_tx_n1", tx1, 1);
      check("single_wave", (cap == 40'b0000_1111_0000_1111_0000_1111_0000_1111_0000_1111) ? 1 : 0, 1);
      check("single_busy_cycles", nbusy, 40);

      // Back-to-back three bytes
      push(8'hA5); push(8'h00); push(8'hFF);
      nbusy = 0; peak = 0; rises = 0; prev_busy = 0;
      for (int i = 0; i < 130; i++) begin
         if (int'(o_level) > peak) peak = int'(o_level);
         nbusy += int'(o_busy);
         if (o_busy && !prev_busy) rises++;
         prev_busy = o_busy;
         @(negedge i_clk);
      end
      check("b2b_busy_cycles", nbusy, 120);
      check("b2b_contiguous", rises, 1);
      check("b2b_peak_level", peak, 2);

      // Overflow with enable low
      i_enable = 0;
      for (int i = 0; i < 17; i++) begin
         push(8'($urandom));
         if (i == 15) begin
            check("ovf_level16", o_level, 16);
            check("ovf_full", o_full, 1);
            check("ovf_not_yet", o_overflow, 0);
         end
      end
      check("ovf_sticky", o_overflow, 1);
      check("ovf_level_after17", o_level, 16);
      i_enable = 1;
      nbusy = 0;
      for (int i = 0; i < 16*40 + 10; i++) begin
         @(negedge i_clk);
         nbusy += int'(o_busy);
      end
      check("ovf_frames_busy", nbusy, 16*40);
      check("ovf_still_set", o_overflow, 1);
      check("ovf_drained", o_empty, 1);

      // Reset during DATA bit 3 of 0x3C with two more queued
      push(8'h3C); push(8'h11); push(8'h22);
      repeat (18) @(negedge i_clk);
      #2 reset = 1;
      #1;
      check("rstmid_tx", o_tx, 1);
      check("rstmid_level", o_level, 0);
      check("rstmid_busy", o_busy, 0);
      check("rstmid_ovf", o_overflow, 0);
      repeat (2) @(negedge i_clk);
      reset = 0;
      nbusy = 0; tx1 = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         nbusy += int'(o_busy);
         if (!o_tx) tx1 = 0;
      end
      check("rstmid_no_frame", nbusy, 0);
      check("rstmid_line_idle", tx1, 1);

      // Enable gating mid-frame
      push(8'hB1); push(8'hC2);
      repeat (15) @(negedge i_clk);
      i_enable = 0;
      repeat (60) @(negedge i_clk);
      check("gate_idle", o_busy, 0);
      check("gate_queued", o_level, 1);
      i_enable = 1;
      @(negedge i_clk);
      check("gate_start_busy0", o_busy, 0);
      @(negedge i_clk);
      check("gate_start_tx", o_tx, 0);
      check("gate_start_busy1", o_busy, 1);
      repeat (45) @(negedge i_clk);

      // Randomized traffic: heavy then light push rate, enable occasionally toggled
      for (int i = 0; i < 4000; i++) begin
         i_wr   = (i < 2000) ? ($urandom % 3 == 0) : ($urandom % 50 == 0);
         i_data = 8'($urandom);
         if ($urandom % 64 == 0) i_enable = ~i_enable;
         @(negedge i_clk);
      end
      i_wr = 0; i_enable = 1;
      begin
         int n;
         n = 0;
         while ((!o_empty || o_busy) && n < DEPTH*10*T + 100) begin
            @(negedge i_clk);
            n++;
         end
         check("drain_bound", (n < DEPTH*10*T + 100) ? 1 : 0, 1);
      end
      repeat (3) @(negedge i_clk);
      chk_on = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
